// File: rtl/kb_cmd_pkg.sv
// Shared constants for the keyboard command scheduler: scan-code bit indices,
// command byte values and the scheduler state encoding.
package kb_cmd_pkg;

    // Bitmap indices are {extend, scancode}
    localparam logic [8:0] SC_W     = 9'h01D;
    localparam logic [8:0] SC_UP    = 9'h175;
    localparam logic [8:0] SC_S     = 9'h01B;
    localparam logic [8:0] SC_DOWN  = 9'h172;
    localparam logic [8:0] SC_A     = 9'h01C;
    localparam logic [8:0] SC_LEFT  = 9'h16B;
    localparam logic [8:0] SC_D     = 9'h023;
    localparam logic [8:0] SC_RIGHT = 9'h174;
    localparam logic [8:0] SC_SPACE = 9'h029;

    localparam logic [7:0] CMD_IDLE  = 8'hA0;
    localparam logic [7:0] CMD_BRAKE = 8'hB0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/kb_cmd_encoder.sv
// Combinational mapping from the key-down bitmap to a drive command byte.
// Opposing directions cancel; brake overrides everything.
module kb_cmd_encoder
    import kb_cmd_pkg::*;
(
    input  logic [511:0] key_down,
    output logic [7:0]   cmd
);

    logic fwd;
    logic back;
    logic left;
    logic right;
    logic brake;

    // Only nine bits matter; the rest of the bitmap is folded into a dead net.
    logic unused_keys;
    assign unused_keys = ^key_down;

    always_comb begin
        fwd   = key_down[SC_W] | key_down[SC_UP];
        back  = key_down[SC_S] | key_down[SC_DOWN];
        left  = key_down[SC_A] | key_down[SC_LEFT];
        right = key_down[SC_D] | key_down[SC_RIGHT];
        brake = key_down[SC_SPACE];
        cmd   = {4'hA, fwd & ~back, back & ~fwd, left & ~right, right & ~left};
        if (brake) begin
            cmd = CMD_BRAKE;
        end
    end

endmodule

// File: rtl/kb_cmd_scheduler.sv
// Snapshots the encoded key command on each key_valid pulse and sends it to the
// UART TX on change or keep-alive expiry, with a minimum idle gap between bytes.
module kb_cmd_scheduler
    import kb_cmd_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 10_000_000,
    parameter int unsigned GAP_CYCLES     = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic         key_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [7:0]   cmd_current,
    output logic         busy
);

    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP_CYCLES - 1);

    sched_state_t  state;
    sched_state_t  state_next;
    logic [7:0]    cmd_new;
    logic [7:0]    cmd_snap;
    logic          pending;
    logic [RW-1:0] refresh_cnt;
    logic [GW-1:0] gap_cnt;
    logic          load;
    logic          accept;
    logic          refresh_hit;
    logic          snap_hit;

    kb_cmd_encoder u_encoder (
        .key_down (key_down),
        .cmd      (cmd_new)
    );

    // Handshake: the byte transfers on a cycle where tx_valid && tx_ready;
    // while tx_valid is high, tx_data is held and tx_valid never drops early.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = SEND;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    state_next = GAP;
                    accept     = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign refresh_hit = (state == IDLE) && (refresh_cnt == REFRESH_LAST);
    assign snap_hit    = key_valid && (cmd_new != cmd_current);
    assign busy        = (state == SEND) || (state == GAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_snap    <= CMD_IDLE;
            pending     <= 1'b0;
            tx_data     <= CMD_IDLE;
            tx_valid    <= 1'b0;
            cmd_current <= CMD_IDLE;
            refresh_cnt <= '0;
            gap_cnt     <= '0;
        end else begin
            if (key_valid) begin
                cmd_snap <= cmd_new;
            end
            // A refresh coinciding with a load is already covered by that byte.
            pending <= (pending & ~load) | snap_hit | (refresh_hit & ~load);

            if (load) begin
                tx_data  <= cmd_snap;
                tx_valid <= 1'b1;
            end
            if (accept) begin
                cmd_current <= tx_data;
                tx_valid    <= 1'b0;
            end

            if (accept) begin
                refresh_cnt <= '0;
            end else if (state == IDLE) begin
                refresh_cnt <= refresh_hit ? '0 : refresh_cnt + RW'(1);
            end

            if (accept) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_kb_cmd_scheduler.sv
// Directed bench for kb_cmd_scheduler and its encoder: one task per scenario,
// accepted bytes captured by a negedge monitor and compared against hand values.
module tb_kb_cmd_scheduler;

    logic         clk;
    logic         rst;
    logic [511:0] key_down;
    logic         key_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   cmd_current;
    logic         busy;

    logic [511:0] key_down_r;
    logic         key_valid_r;
    logic [7:0]   tx_data_r;
    logic         tx_valid_r;
    logic         tx_ready_r;
    logic [7:0]   cmd_current_r;
    logic         busy_r;

    logic [511:0] enc_keys;
    logic [7:0]   enc_cmd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] acc_q[$];
    logic [7:0] acc_r_q[$];
    int         acc_r_t[$];

    kb_cmd_scheduler #(.REFRESH_CYCLES(20000), .GAP_CYCLES(4)) dut (
        .clk (clk), .rst (rst), .key_down (key_down), .key_valid (key_valid),
        .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
        .cmd_current (cmd_current), .busy (busy)
    );

    kb_cmd_scheduler #(.REFRESH_CYCLES(100), .GAP_CYCLES(4)) dut_r (
        .clk (clk), .rst (rst), .key_down (key_down_r), .key_valid (key_valid_r),
        .tx_data (tx_data_r), .tx_valid (tx_valid_r), .tx_ready (tx_ready_r),
        .cmd_current (cmd_current_r), .busy (busy_r)
    );

    kb_cmd_encoder u_enc (
        .key_down (enc_keys),
        .cmd      (enc_cmd)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) acc_q.push_back(tx_data);
        if (tx_valid_r && tx_ready_r) begin
            acc_r_q.push_back(tx_data_r);
            acc_r_t.push_back(cyc);
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [511:0] mk(input int a, input int b = -1, input int c = -1);
        logic [511:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [511:0] kd);
        @(posedge clk);
        #1;
        key_down  = kd;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_encoder;
        logic [511:0] vk[14];
        logic [7:0]   ve[14];
        vk[0]  = mk(-1);                ve[0]  = 8'hA0;
        vk[1]  = mk('h01D);             ve[1]  = 8'hA8;
        vk[2]  = mk('h175);             ve[2]  = 8'hA8;
        vk[3]  = mk('h01B);             ve[3]  = 8'hA4;
        vk[4]  = mk('h172);             ve[4]  = 8'hA4;
        vk[5]  = mk('h01C);             ve[5]  = 8'hA2;
        vk[6]  = mk('h16B);             ve[6]  = 8'hA2;
        vk[7]  = mk('h023);             ve[7]  = 8'hA1;
        vk[8]  = mk('h174);             ve[8]  = 8'hA1;
        vk[9]  = mk('h01D, 'h01B);      ve[9]  = 8'hA0;
        vk[10] = mk('h01C, 'h174);      ve[10] = 8'hA0;
        vk[11] = mk('h175, 'h023);      ve[11] = 8'hA9;
        vk[12] = mk('h029, 'h01D, 'h01C); ve[12] = 8'hB0;
        vk[13] = mk('h11D);             ve[13] = 8'hA0;
        for (int i = 0; i < 14; i++) begin
            enc_keys = vk[i];
            #1;
            checks++;
            if (enc_cmd !== ve[i]) begin
                errors++;
                $display("FAIL encoder[%0d]: got %h expected %h", i, enc_cmd, ve[i]);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: tx_valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        checks++;
        if (tx_data !== 8'hA0) begin
            errors++;
            $display("FAIL reset_tx_data: got %h expected a0", tx_data);
        end
        checks++;
        if (cmd_current !== 8'hA0) begin
            errors++;
            $display("FAIL reset_cmd_current: got %h expected a0", cmd_current);
        end
    endtask

    task automatic test_first_byte;
        acc_q.delete();
        pulse(mk('h01D));
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_early: tx_valid=%b expected 0 one cycle after pulse", tx_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA8) begin
            errors++;
            $display("FAIL first_latency: tx_valid=%b tx_data=%h expected 1 a8", tx_valid, tx_data);
        end
        settle(12);
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 8'hA8) begin
            errors++;
            $display("FAIL first_count: got %0d bytes first=%h expected 1 byte a8",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'h00);
        end
        checks++;
        if (cmd_current !== 8'hA8) begin
            errors++;
            $display("FAIL first_cmd_current: got %h expected a8", cmd_current);
        end
    endtask

    task automatic test_sequence;
        logic [7:0] exp_q[$];
        acc_q.delete();
        pulse(mk('h01D, 'h01C));          exp_q.push_back(8'hAA); settle(12);
        pulse(mk('h01D, 'h01C, 'h01B));   exp_q.push_back(8'hA2); settle(12);
        key_down = mk('h01D, 'h01C, 'h01B);
        key_down[9'h029] = 1'b1;
        pulse(key_down);                  exp_q.push_back(8'hB0); settle(12);
        pulse(mk(-1));                    exp_q.push_back(8'hA0); settle(12);
        checks++;
        if (acc_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL seq_count: got %0d bytes expected %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (acc_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL seq_byte[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int bad;
        int n;
        acc_q.delete();
        tx_ready = 1'b0;
        pulse(mk('h023));
        @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin key_down = mk('h01D); key_valid = 1'b1; end
            if (i == 25) begin key_down = mk('h01B); key_valid = 1'b1; end
            if (i == 11 || i == 26) key_valid = 1'b0;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA1) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d cycles with tx_valid/tx_data off, expected 0 (held a1)", bad);
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_accept: tx_valid=%b busy=%b expected 0 1", tx_valid, busy);
        end
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL bp_gap: next tx_valid after %0d cycles expected 5", n);
        end
        settle(12);
        checks++;
        if (acc_q.size() != 2 || acc_q[0] !== 8'hA1 || acc_q[1] !== 8'hA4) begin
            errors++;
            $display("FAIL bp_bytes: got %0d bytes (%h %h) expected 2 (a1 a4)", acc_q.size(),
                     (acc_q.size() > 0) ? acc_q[0] : 8'h00, (acc_q.size() > 1) ? acc_q[1] : 8'h00);
        end
        checks++;
        if (cmd_current !== 8'hA4) begin
            errors++;
            $display("FAIL bp_cmd_current: got %h expected a4", cmd_current);
        end
    endtask

    task automatic test_no_change;
        acc_q.delete();
        pulse(mk('h01B));
        settle(12);
        checks++;
        if (acc_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nochange: got %0d bytes busy=%b expected 0 0", acc_q.size(), busy);
        end
        pulse(mk('h175));
        settle(12);
        pulse(mk('h16B, 'h174));
        settle(12);
        checks++;
        if (acc_q.size() != 2 || acc_q[0] !== 8'hA8 || acc_q[1] !== 8'hA0) begin
            errors++;
            $display("FAIL arrows: got %0d bytes (%h %h) expected 2 (a8 a0)", acc_q.size(),
                     (acc_q.size() > 0) ? acc_q[0] : 8'h00, (acc_q.size() > 1) ? acc_q[1] : 8'h00);
        end
    endtask

    task automatic test_reset_mid_send;
        int n;
        tx_ready = 1'b0;
        pulse(mk('h023));
        n = 0;
        while (tx_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_send_setup: tx_valid=%b expected 1 before reset", tx_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: tx_valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        checks++;
        if (tx_data !== 8'hA0 || cmd_current !== 8'hA0) begin
            errors++;
            $display("FAIL rst_values: tx_data=%h cmd_current=%h expected a0 a0", tx_data, cmd_current);
        end
        settle(2);
        rst = 1'b1;
        tx_ready = 1'b1;
        acc_q.delete();
        settle(30);
        checks++;
        if (acc_q.size() != 0 || tx_data !== 8'hA0 || cmd_current !== 8'hA0) begin
            errors++;
            $display("FAIL rst_quiet: got %0d bytes tx_data=%h cmd_current=%h expected 0 a0 a0",
                     acc_q.size(), tx_data, cmd_current);
        end
    endtask

    task automatic test_refresh;
        int n;
        int tp;
        acc_r_q.delete();
        acc_r_t.delete();
        n = 0;
        while (acc_r_t.size() < 3 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (acc_r_t.size() < 3) begin
            errors++;
            $display("FAIL refresh_timeout: got %0d bytes expected 3", acc_r_t.size());
            return;
        end
        checks++;
        if (acc_r_t[1] - acc_r_t[0] != 106 || acc_r_t[2] - acc_r_t[1] != 106) begin
            errors++;
            $display("FAIL refresh_spacing: got %0d %0d expected 106 106",
                     acc_r_t[1] - acc_r_t[0], acc_r_t[2] - acc_r_t[1]);
        end
        checks++;
        if (acc_r_q[0] !== 8'hA0 || acc_r_q[1] !== 8'hA0 || acc_r_q[2] !== 8'hA0) begin
            errors++;
            $display("FAIL refresh_bytes: got %h %h %h expected a0 a0 a0",
                     acc_r_q[0], acc_r_q[1], acc_r_q[2]);
        end
        settle(30);
        key_down_r  = mk('h01D);
        key_valid_r = 1'b1;
        tp = cyc;
        @(posedge clk);
        #1;
        key_valid_r = 1'b0;
        n = 0;
        while (acc_r_t.size() < 5 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (acc_r_t.size() < 5) begin
            errors++;
            $display("FAIL refresh_restart_timeout: got %0d bytes expected 5", acc_r_t.size());
            return;
        end
        checks++;
        if (acc_r_q[3] !== 8'hA8 || acc_r_t[3] != tp + 2) begin
            errors++;
            $display("FAIL refresh_key: got %h at +%0d expected a8 at +2", acc_r_q[3], acc_r_t[3] - tp);
        end
        checks++;
        if (acc_r_q[4] !== 8'hA8 || acc_r_t[4] - acc_r_t[3] != 106) begin
            errors++;
            $display("FAIL refresh_restart: got %h spacing %0d expected a8 106",
                     acc_r_q[4], acc_r_t[4] - acc_r_t[3]);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst         = 1'b0;
        key_down    = '0;
        key_valid   = 1'b0;
        tx_ready    = 1'b1;
        key_down_r  = '0;
        key_valid_r = 1'b0;
        tx_ready_r  = 1'b1;
        enc_keys    = '0;
        #12;
        test_reset();
        test_encoder();
        @(posedge clk);
        #1;
        rst = 1'b1;
        settle(2);
        test_first_byte();
        test_sequence();
        test_backpressure();
        test_no_change();
        test_reset_mid_send();
        test_refresh();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
